serial_ripple_adder: RTL and testbench

- Bit-serial adder: one full-adder cell plus a carry flip-flop add two WIDTH-bit operands, one bit per clock, LSB first.
- It is the addition counterpart to the team's combinational ripple-carry subtractor.
- Used where area matters more than latency; the start/done handshake lets a controller sequence operations.

---
 rtl/serial_ripple_adder.sv | 94 +++++++++
 tb/tb_serial_ripple_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_adder.sv
// Bit-serial adder: {cout,sum} = a+b+cin, one bit per cycle, LSB first, start/done handshake.
// Latency WIDTH cycles from accepted start to done; start ignored while busy. Optional ovf via SERIAL_ADDER_OVF_EN.
module serial_ripple_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_next;
   logic             last_bit;

   always_comb begin
      s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
      c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // Sum bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
               res_sr <= {s_bit, res_sr[WIDTH-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= c_next;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  sum   <= {s_bit, res_sr[WIDTH-1:1]};
                  cout  <= c_next;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry still holds the carry into the MSB on this edge
                  ovf   <= carry ^ c_next;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Self-checking bench for serial_ripple_adder (WIDTH=4): vector table plus handshake corner cases.
module tb_serial_ripple_adder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   serial_ripple_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   vec_t vecs[11];
   exp_t sb[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum  = s;
      e.cout = c;
      e.ovf  = o;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: done with no expected result queued at %0t", $time);
      end else begin
         e = sb.pop_front();
         check("sum", 32'(sum), 32'(e.sum));
         check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
         check("ovf", 32'(ovf), 32'(e.ovf));
`endif
         last_exp = e;
      end
   endtask

   // One operation with cycle-exact busy/done checks; noise drives start while busy.
   task automatic run_op(input vec_t v, input bit noise);
      a = v.a; b = v.b; cin = v.cin; start = 1'b1;
      tick();
      push_exp(v.sum, v.cout, v.ovf);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      check("done_after_start", 32'(done), 32'd0);
      for (int k = 1; k <= W; k++) begin
         if (noise && k < W) begin
            start = 1'b1; a = 4'hF; b = 4'hF;
         end else begin
            start = 1'b0;
         end
         tick();
         check("busy_run", 32'(busy), 32'(k < W));
         check("done_timing", 32'(done), 32'(k == W));
         if (k < W) check("sum_hold_run", 32'(sum), 32'(last_exp.sum));
         else pop_check();
      end
      start = 1'b0;
      tick();
      check("done_single_pulse", 32'(done), 32'd0);
      check("sum_hold_idle", 32'(sum), 32'(last_exp.sum));
      check("cout_hold_idle", 32'(cout), 32'(last_exp.cout));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //           a      b    cin  sum   cout ovf
      vecs[0]  = '{4'd9,  4'd5,  1'b0, 4'd14, 1'b0, 1'b0};
      vecs[1]  = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
      vecs[2]  = '{4'd7,  4'd8,  1'b1, 4'd0,  1'b1, 1'b0};
      vecs[3]  = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
      vecs[4]  = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
      vecs[5]  = '{4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0};
      vecs[6]  = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0};
      vecs[7]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
      vecs[8]  = '{4'd10, 4'd10, 1'b0, 4'd4,  1'b1, 1'b1};
      vecs[9]  = '{4'd5,  4'd10, 1'b0, 4'd15, 1'b0, 1'b0};
      vecs[10] = '{4'd12, 4'd6,  1'b1, 4'd3,  1'b1, 1'b0};

      last_exp = '{4'd0, 1'b0, 1'b0};
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset_ovf", 32'(ovf), 32'd0);
`endif

      foreach (vecs[i]) run_op(vecs[i], 1'b0);

      // start while busy must be ignored
      run_op('{4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0}, 1'b1);

      // reset during RUN discards the operation
      a = 4'd6; b = 4'd6; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_exp = '{4'd0, 1'b0, 1'b0};
      check("midrun_rst_busy", 32'(busy), 32'd0);
      check("midrun_rst_done", 32'(done), 32'd0);
      check("midrun_rst_sum", 32'(sum), 32'd0);
      check("midrun_rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("midrun_rst_ovf", 32'(ovf), 32'd0);
`endif
      for (int k = 0; k < W + 2; k++) begin
         tick();
         check("no_done_after_rst", 32'(done), 32'd0);
         check("no_busy_after_rst", 32'(busy), 32'd0);
      end

      // back-to-back: second start held during the done cycle
      a = 4'd2; b = 4'd3; cin = 1'b0; start = 1'b1;
      tick();
      push_exp(4'd5, 1'b0, 1'b0);
      start = 1'b0;
      for (int k = 1; k <= W; k++) begin
         tick();
         check("b2b_first_done", 32'(done), 32'(k == W));
      end
      pop_check();
      a = 4'd10; b = 4'd10; cin = 1'b0; start = 1'b1;
      tick();
      push_exp(4'd4, 1'b1, 1'b1);
      start = 1'b0;
      check("b2b_accept_busy", 32'(busy), 32'd1);
      check("b2b_accept_done", 32'(done), 32'd0);
      check("b2b_sum_hold", 32'(sum), 32'd5);
      for (int k = 1; k <= W; k++) begin
         tick();
         check("b2b_second_done", 32'(done), 32'(k == W));
         check("b2b_second_busy", 32'(busy), 32'(k < W));
      end
      pop_check();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
